obc_slice_feeder: RTL

OBC_SLICE_FEEDER -- requirements
Module: obc_slice_feeder

---
 rtl/obc_pkg.sv | 17 +
 rtl/obc_slice_feeder_if.sv | 27 ++
 rtl/obc_bit_counter.sv | 31 +++
 rtl/obc_slice_feeder.sv | 89 ++++++++
 4 files changed

// File: rtl/obc_pkg.sv
// Shared defaults, FSM state type and index-width helper for the OBC slice feeder.
package obc_pkg;

    localparam int DEF_N  = 8;
    localparam int DEF_DW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of the bit-slice index; DW=2 still needs one bit.
    function automatic int kWidth(input int dw);
        return (dw > 2) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/obc_slice_feeder_if.sv
// Block-in / slice-out handshake bundle between the sample source, the feeder and the ROM side.
interface obc_slice_feeder_if #(
    parameter int N  = obc_pkg::DEF_N,
    parameter int DW = obc_pkg::DEF_DW
);

    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            slice_valid;
    logic            slice_ready;
    logic [N-1:0]    slice;
    logic            slice_first;
    logic            slice_last;
    logic            busy;

    modport slave (
        input  in_valid, in_data, slice_ready,
        output in_ready, slice_valid, slice, slice_first, slice_last, busy
    );

    modport master (
        output in_valid, in_data, slice_ready,
        input  in_ready, slice_valid, slice, slice_first, slice_last, busy
    );

endinterface

// File: rtl/obc_bit_counter.sv
// Bit-slice index counter: clear has priority, counting saturates at DW-1.
module obc_bit_counter #(
    parameter int DW = 16,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_clr,
    output logic [KW-1:0] o_k,
    output logic          o_last
);

    localparam logic [KW-1:0] LAST_K = KW'(DW - 1);

    logic [KW-1:0] r_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
        end else if (i_clr) begin
            r_k <= '0;
        end else if (i_en && !o_last) begin
            r_k <= r_k + KW'(1);
        end
    end

    assign o_k    = r_k;
    assign o_last = (r_k == LAST_K);

endmodule

// File: rtl/obc_slice_feeder.sv
// Holds one block of N samples and presents it to the OBC ROMs one bit-slice per transfer, LSB first.
module obc_slice_feeder
    import obc_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW      = DEF_DW,
    parameter int INV_MSB = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    obc_slice_feeder_if.slave  bus
);

    localparam int   KW      = kWidth(DW);
    localparam logic INV_BIT = (INV_MSB != 0);

    state_t          r_state;
    state_t          w_next;
    logic [N*DW-1:0] r_samples;
    logic [KW-1:0]   w_k;
    logic            w_kLast;
    logic            w_valid;
    logic            w_xfer;
    logic            w_ready;
    logic            w_capture;
    logic [DW-1:0]   w_sample;
    logic [N-1:0]    w_slice;

    assign w_valid   = (r_state == RUN);
    assign w_xfer    = w_valid & bus.slice_ready;
    // The final transfer of a block reopens the input so the next block follows with no bubble.
    assign w_ready   = ~w_valid | (w_xfer & w_kLast);
    assign w_capture = bus.in_valid & w_ready;

    obc_bit_counter #(
        .DW (DW),
        .KW (KW)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_xfer),
        .i_clr  (w_capture),
        .o_k    (w_k),
        .o_last (w_kLast)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = RUN;
            RUN:     if (w_xfer && w_kLast && !bus.in_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samples <= '0;
        end else if (w_capture) begin
            r_samples <= bus.in_data;
        end
    end

    // The sign slice is optionally inverted for offset-binary ROM addressing.
    always_comb begin
        w_sample = '0;
        w_slice  = '0;
        for (int i = 0; i < N; i++) begin
            w_sample   = r_samples[i*DW +: DW];
            w_slice[i] = w_valid & (w_sample[w_k] ^ (w_kLast & INV_BIT));
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.slice_valid = w_valid;
    assign bus.slice       = w_slice;
    assign bus.slice_first = w_valid & (w_k == '0);
    assign bus.slice_last  = w_valid & w_kLast;
    assign bus.busy        = w_valid;

endmodule
